alu_bit_serial_sequencer: RTL and testbench
===========================================

Name: alu_bit_serial_sequencer

Overview:
Multi-cycle W-bit ALU that drives a single 1-bit ALU slice iteratively, LSB first. It supplies op and carry-in to the slice each cycle and consumes the slice's result and carry-out. It sits beside the datapath as a low-area alternative to a ripple array. It uses a valid/ready request port and a valid/ready response port.

Parameters:
WIDTH, 64, operand/result width in bits (>=2); also the number of RUN cycles per operation.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
start_valid  in  1  request valid
start_ready  out  1  request accepted when start_valid & start_ready at rising edge
a_in  in  WIDTH  operand A, sampled only at acceptance
b_in  in  WIDTH  operand B, sampled only at acceptance
alu_op  in  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR; sampled only at acceptance
result  out  WIDTH  registered result
zero  out  1  result == 0
carry_out  out  1  final carry (ADD/SUB), else 0
overflow  out  1  signed overflow (ADD/SUB), else 0
result_valid  out  1  response valid
result_ready  in  1  response consumed when result_valid & result_ready at rising edge

Behaviour:
- Reset (reset_n low, asynchronous) forces state=IDLE, result=0, zero=0, carry_out=0, overflow=0, result_valid=0. Internal shift registers, bit counter and carry are cleared. start_ready is 0 while reset_n is low.
- Reset mid-operation aborts the operation; no result is produced.
- States: IDLE, RUN, DONE.
- IDLE: start_ready=1.
  - On acceptance, latch a_in, b_in and alu_op; set counter=0; set carry=1 for SUB, 0 otherwise; go to RUN.
- RUN: start_ready=0. Each cycle processes bit i = counter:
  - b_eff = ~b[i] for SUB, b[i] otherwise.
  - Bit result: AND a&b; OR a|b; ADD/SUB a^b_eff^carry; NOR ~(a|b).
  - carry <= (a&b_eff)|(a&carry)|(b_eff&carry) for ADD/SUB; carry is unused for logic ops.
  - The result bit is shifted into the result shift register from the MSB side, so after WIDTH shifts bit 0 sits at the LSB.
  - On the cycle with i=WIDTH-1, record carry-in to the MSB for overflow.
  - After WIDTH RUN cycles, go to DONE.
- Entering DONE, all of the following are registered on the same edge:
  - result, zero=(result==0), carry_out (ADD/SUB final carry, else 0), overflow (carry into MSB XOR carry out of MSB for ADD/SUB, else 0).
  - result_valid=1.
- Latency: result_valid rises exactly WIDTH rising edges after the acceptance edge.
- DONE: result_valid holds 1 and all outputs are stable until result_ready=1 at a rising edge; then result_valid=0 and the state returns to IDLE.
- Outputs retain their last values in IDLE and RUN until the next DONE update.
- start_ready=0 in RUN and DONE. start_valid in those states is ignored, not queued.
- Simultaneous result_ready and start_valid in DONE: only the response handshake completes. The earliest new acceptance is the next cycle (IDLE).
- Throughput: at most one operation per WIDTH+2 cycles.
- Unsupported alu_op: still runs WIDTH cycles. result=0, zero=1, carry_out=0, overflow=0.
- Operand inputs may change freely after acceptance without affecting the operation in progress.

Test Plan:
1. WIDTH=8, ADD a=0x7F b=0x01 -> result 0x80, carry_out 0, overflow 1, zero 0; result_valid rises exactly 8 edges after acceptance.
2. WIDTH=8, SUB a=0x05 b=0x05 -> result 0x00, zero 1, carry_out 1, overflow 0. Then SUB a=0x80 b=0x01 -> 0x7F, overflow 1, carry_out 1.
3. WIDTH=8, a=0xF0 b=0x3C: AND -> 0x30; OR -> 0xFC; NOR -> 0x03. All three have carry_out 0 and overflow 0.
4. Backpressure: after 0x12+0x34, hold result_ready=0 for 5 cycles with start_valid=1 throughout -> result 0x46 and result_valid stay stable, start_ready stays 0. Raising result_ready -> IDLE next cycle, and the pending start is accepted one cycle later.
5. Reset mid-RUN: pulse reset_n low asynchronously at bit 3 of an ADD -> outputs 0 immediately and no result_valid. After release, start_ready=1 and a fresh ADD 0x01+0x02 -> 0x03.
6. WIDTH=64: ADD 0xFFFF_FFFF_FFFF_FFFF + 1 -> result 0, zero 1, carry_out 1, overflow 0, result_valid after 64 edges. alu_op=4'b1111 -> result 0, zero 1, flags 0.

Source files
------------

// File: rtl/alu_bit_serial_sequencer.sv
// alu_bit_serial_sequencer: multi-cycle W-bit ALU driving a 1-bit slice LSB first with valid/ready request and response ports
module alu_bit_serial_sequencer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             result_valid,
  input  logic             result_ready
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state;
  logic [WIDTH-1:0] r_a, r_b, r_sh;
  logic [3:0] r_op;
  logic [CW-1:0] r_cnt;
  logic r_carry;
  logic w_arith, w_sub, w_be, w_bit, w_cout, w_last;
  logic [WIDTH-1:0] w_res;
  assign w_sub = r_op == 4'b0110;
  assign w_arith = w_sub | (r_op == 4'b0010);
  assign w_be = r_b[0] ^ w_sub;
  always_comb
    w_bit = r_op == 4'b0000 ? r_a[0] & r_b[0] :
            r_op == 4'b0001 ? r_a[0] | r_b[0] :
            w_arith         ? r_a[0] ^ w_be ^ r_carry :
            r_op == 4'b1100 ? ~(r_a[0] | r_b[0]) : 1'b0;
  assign w_cout = (r_a[0] & w_be) | (r_a[0] & r_carry) | (w_be & r_carry);
  assign w_last = r_cnt == CW'(WIDTH - 1);
  assign w_res = {w_bit, r_sh[WIDTH-1:1]};
  assign start_ready = reset_n && r_state == IDLE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_a <= '0;
      r_b <= '0;
      r_sh <= '0;
      r_op <= '0;
      r_cnt <= '0;
      r_carry <= 1'b0;
      result <= '0;
      zero <= 1'b0;
      carry_out <= 1'b0;
      overflow <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start_valid) begin
          r_a <= a_in;
          r_b <= b_in;
          r_op <= alu_op;
          r_cnt <= '0;
          r_carry <= alu_op == 4'b0110;
          r_state <= RUN;
        end
        RUN: begin
          r_a <= r_a >> 1;
          r_b <= r_b >> 1;
          r_sh <= w_res;
          r_cnt <= r_cnt + CW'(1);
          r_carry <= w_arith ? w_cout : r_carry;
          // r_carry holds the carry into the MSB on the last bit
          if (w_last) begin
            result <= w_res;
            zero <= ~|w_res;
            carry_out <= w_arith & w_cout;
            overflow <= w_arith & (r_carry ^ w_cout);
            result_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: if (result_ready) begin
          result_valid <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_bit_serial_sequencer.sv
// tb_alu_bit_serial_sequencer: random and directed checks of 8- and 64-bit instances against an arithmetic model
module tb_alu_bit_serial_sequencer;
  logic clk = 0, reset_n = 1, sel = 0, sv = 0, rr = 0;
  logic [63:0] a = 0, b = 0;
  logic [3:0] op = 0;
  logic rdy8, v8, z8, c8, o8, rdy64, v64, z64, c64, o64;
  logic [7:0] res8;
  logic [63:0] res64;
  logic m_ready, m_valid, m_z, m_c, m_v;
  logic [63:0] m_res;
  logic [63:0] e_res;
  logic e_z, e_c, e_v;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  alu_bit_serial_sequencer #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .start_valid(sv & ~sel), .start_ready(rdy8),
    .a_in(a[7:0]), .b_in(b[7:0]), .alu_op(op), .result(res8), .zero(z8),
    .carry_out(c8), .overflow(o8), .result_valid(v8), .result_ready(rr & ~sel));
  alu_bit_serial_sequencer #(.WIDTH(64)) u64 (
    .clk(clk), .reset_n(reset_n), .start_valid(sv & sel), .start_ready(rdy64),
    .a_in(a), .b_in(b), .alu_op(op), .result(res64), .zero(z64),
    .carry_out(c64), .overflow(o64), .result_valid(v64), .result_ready(rr & sel));
  always_comb begin
    m_ready = sel ? rdy64 : rdy8;
    m_valid = sel ? v64 : v8;
    m_res = sel ? res64 : {56'd0, res8};
    m_z = sel ? z64 : z8;
    m_c = sel ? c64 : c8;
    m_v = sel ? o64 : o8;
  end
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask
  function automatic void model(input int n, input logic [63:0] x, input logic [63:0] y,
                                input logic [3:0] o, output logic [63:0] r,
                                output logic z, output logic c, output logic v);
    logic [63:0] m, xa, ya;
    logic [64:0] s;
    m = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    xa = x & m;
    ya = y & m;
    c = 0;
    v = 0;
    case (o)
      4'b0000: r = xa & ya;
      4'b0001: r = xa | ya;
      4'b1100: r = ~(xa | ya) & m;
      4'b0010: begin
        s = {1'b0, xa} + {1'b0, ya};
        r = s[63:0] & m;
        c = s[n];
        v = (xa[n-1] == ya[n-1]) && (r[n-1] != xa[n-1]);
      end
      4'b0110: begin
        r = (xa - ya) & m;
        c = xa >= ya;
        v = (xa[n-1] != ya[n-1]) && (r[n-1] != xa[n-1]);
      end
      default: r = 0;
    endcase
    z = r == 0;
  endfunction
  always @(negedge clk)
    if (reset_n && m_valid) begin
      chk("res", m_res, e_res);
      chk("zero", m_z, e_z);
      chk("carry", m_c, e_c);
      chk("ovf", m_v, e_v);
      chk("ready_in_done", m_ready, 0);
    end
  task automatic send(input logic s, input logic [63:0] x, input logic [63:0] y, input logic [3:0] o);
    int k = 0;
    sel = s;
    a = x;
    b = y;
    op = o;
    model(s ? 64 : 8, x, y, o, e_res, e_z, e_c, e_v);
    sv = 1;
    while (!m_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("accept_wait", k < 200, 1);
    @(posedge clk); #1;
    sv = 0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    op = 4'($urandom);
  endtask
  task automatic wait_valid();
    int k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!m_valid && k < 200);
    chk("latency", k, sel ? 64 : 8);
  endtask
  task automatic finish_op();
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    rr = 1;
    @(posedge clk); #1;
    rr = 0;
    chk("valid_drop", m_valid, 0);
    chk("idle_ready", m_ready, 1);
  endtask
  task automatic lit(input logic [63:0] r, input logic z, input logic c, input logic v);
    chk("lit_res", m_res, r);
    chk("lit_zero", m_z, z);
    chk("lit_carry", m_c, c);
    chk("lit_ovf", m_v, v);
  endtask
  task automatic run(input logic s, input logic [63:0] x, input logic [63:0] y, input logic [3:0] o);
    send(s, x, y, o);
    wait_valid();
  endtask
  initial begin
    logic [3:0] ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1111};
    #2 reset_n = 0;
    #1;
    lit(0, 0, 0, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_ready", m_ready, 0);
    #19 reset_n = 1;
    @(posedge clk); #1;
    chk("post_rst_ready", m_ready, 1);
    run(0, 64'h7F, 64'h01, 4'b0010); lit(64'h80, 0, 0, 1); finish_op();
    run(0, 64'h05, 64'h05, 4'b0110); lit(64'h00, 1, 1, 0); finish_op();
    run(0, 64'h80, 64'h01, 4'b0110); lit(64'h7F, 0, 1, 1); finish_op();
    run(0, 64'hF0, 64'h3C, 4'b0000); lit(64'h30, 0, 0, 0); finish_op();
    run(0, 64'hF0, 64'h3C, 4'b0001); lit(64'hFC, 0, 0, 0); finish_op();
    run(0, 64'hF0, 64'h3C, 4'b1100); lit(64'h03, 0, 0, 0); finish_op();
    run(0, 64'h12, 64'h34, 4'b0010); lit(64'h46, 0, 0, 0);
    a = 64'h01;
    b = 64'h01;
    op = 4'b0010;
    sv = 1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_valid", m_valid, 1);
      chk("bp_res", m_res, 64'h46);
      chk("bp_ready", m_ready, 0);
    end
    rr = 1;
    @(posedge clk); #1;
    rr = 0;
    chk("bp_drop", m_valid, 0);
    chk("bp_idle", m_ready, 1);
    model(8, a, b, op, e_res, e_z, e_c, e_v);
    @(posedge clk); #1;
    sv = 0;
    chk("bp_accepted", m_ready, 0);
    wait_valid(); lit(64'h02, 0, 0, 0); finish_op();
    send(0, 64'h11, 64'h22, 4'b0010);
    repeat (3) @(posedge clk);
    #2 reset_n = 0;
    #1;
    lit(0, 0, 0, 0);
    chk("abort_valid", m_valid, 0);
    chk("abort_ready", m_ready, 0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("abort_no_result", m_valid, 0);
    end
    chk("abort_idle", m_ready, 1);
    run(0, 64'h01, 64'h02, 4'b0010); lit(64'h03, 0, 0, 0); finish_op();
    run(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'b0010); lit(0, 1, 1, 0); finish_op();
    run(1, 64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 4'b1111); lit(0, 1, 0, 0); finish_op();
    run(1, 64'h8000_0000_0000_0000, 64'h1, 4'b0110); lit(64'h7FFF_FFFF_FFFF_FFFF, 0, 1, 1); finish_op();
    repeat (40) begin
      logic s;
      logic [3:0] o;
      s = $urandom_range(0, 3) == 0;
      o = $urandom_range(0, 7) == 0 ? 4'($urandom) : ops[$urandom_range(0, 5)];
      run(s, {$urandom, $urandom}, $urandom_range(0, 1) ? {$urandom, $urandom} : 64'h0, o);
      finish_op();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
